// File: rtl/load_store_unit.sv
// Load/store unit between the MIPS datapath and a word-addressed data memory.
// Optional statistics counters are enabled with `define LSU_STATS_EN.
module load_store_unit #(
  parameter int MEM_AW    = 6,
  parameter int MEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
`ifdef LSU_STATS_EN
  ,
  output logic [15:0]       load_count,
  output logic [15:0]       store_count,
  output logic [15:0]       err_count
`endif
);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE_W,
    RMW_RD,
    RMW_WR,
    ERR,
    RESP
  } state_e;

  state_e            state;
  size_e             size_q;
  logic              unsigned_q;
  logic [MEM_AW+1:0] addr_q;
  // Word stores go straight to mem_wd at accept; only sub-word data is kept.
  logic [15:0]       wdata_q;
`ifdef LSU_STATS_EN
  logic              we_q;
`endif

  logic accept;
  logic bad_size;
  logic misaligned;
  logic out_of_range;
  logic illegal;

  assign accept       = req_valid & req_ready;
  assign bad_size     = (req_size == SZ_BAD);
  assign misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign out_of_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
  assign illegal      = bad_size | misaligned | out_of_range;

  assign mem_addr     = addr_q[MEM_AW+1:2];

  // Little-endian lane select with sign or zero extension.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input size_e       size,
                                              input logic        uns);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = 8'(word >> {off, 3'b000});
    lane_h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: return uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [1:0]  off,
                                              input size_e       size,
                                              input logic [15:0] data);
    logic [31:0] mask;
    logic [31:0] lanes;
    if (size == SZ_HALF) begin
      mask  = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      lanes = {2{data}};
    end else begin
      mask  = 32'h0000_00FF << {off, 3'b000};
      lanes = {4{data[7:0]}};
    end
    return (old & ~mask) | (lanes & mask);
  endfunction

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_we     <= 1'b0;
      mem_wd     <= 32'h0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 16'h0;
`ifdef LSU_STATS_EN
      we_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            size_q     <= size_e'(req_size);
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr[MEM_AW+1:0];
            wdata_q    <= req_wdata[15:0];
`ifdef LSU_STATS_EN
            we_q       <= req_we;
`endif
            req_ready  <= 1'b0;
            if (illegal) begin
              state <= ERR;
            end else if (!req_we) begin
              state <= LOAD;
            end else if (req_size == SZ_WORD) begin
              state  <= STORE_W;
              mem_we <= 1'b1;
              mem_wd <= req_wdata;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_extend(mem_rd, addr_q[1:0], size_q, unsigned_q);
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_RD: begin
          mem_we <= 1'b1;
          mem_wd <= store_merge(mem_rd, addr_q[1:0], size_q, wdata_q);
          state  <= RMW_WR;
        end
        STORE_W, RMW_WR: begin
          mem_we     <= 1'b0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        ERR: begin
          resp_rdata <= 32'h0;
          resp_err   <= 1'b1;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          mem_we    <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef LSU_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      load_count  <= 16'h0;
      store_count <= 16'h0;
      err_count   <= 16'h0;
    end else if (state == RESP) begin
      if (resp_err)  err_count   <= sat_inc(err_count);
      else if (we_q) store_count <= sat_inc(store_count);
      else           load_count  <= sat_inc(load_count);
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// traffic against a byte-level reference model of the data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [5:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
`ifdef LSU_STATS_EN
  logic [15:0] load_count;
  logic [15:0] store_count;
  logic [15:0] err_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx;
  logic [31:0] poke_data;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_AW(6), .MEM_WORDS(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef LSU_STATS_EN
    , .load_count(load_count), .store_count(store_count), .err_count(err_count)
`endif
  );

  // Bench data memory: combinational read, write on clk.
  always @(posedge clk) begin
    if (poke_en)     mem[poke_idx] <= poke_data;
    else if (mem_we) mem[mem_addr] <= mem_wd;
  end
  assign mem_rd = mem[mem_addr];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = 6'(idx); poke_data = data;
    @(posedge clk);
    #1 poke_en = 1'b0;
    ref_mem[idx] = data;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issues one request and records what the DUT does until resp_valid.
  // lat = 0 means no response within the cycle budget.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int we_cnt, output int we_cyc,
                        output logic [31:0] wd);
    rdata = 32'hDEAD_BEEF; err = 1'bx; lat = 0; we_cnt = 0; we_cyc = 0; wd = 32'h0;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_unsigned = 1'($urandom);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_we) begin we_cnt++; we_cyc = c; wd = mem_wd; end
      if (resp_valid) begin lat = c; rdata = resp_rdata; err = resp_err; break; end
    end
  endtask

  // Reference behaviour from the architectural rules; updates ref_mem on stores.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output int wes);
    int unsigned idx, off, sh, v;
    logic [31:0] word, mask;
    idx = addr / 4; off = addr % 4;
    err = (size == 3) || (size == 1 && off % 2 != 0) || (size == 2 && off != 0) || idx >= 64;
    rdata = 0; lat = 2; wes = 0;
    if (err) return;
    word = ref_mem[idx];
    if (!we) begin
      if (size == 0) begin
        v = (word >> (8 * off)) % 256;
        rdata = (!uns && v >= 128) ? v + 32'hFFFF_FF00 : v;
      end else if (size == 1) begin
        v = (word >> (8 * off)) % 65536;
        rdata = (!uns && v >= 32768) ? v + 32'hFFFF_0000 : v;
      end else begin
        rdata = word;
      end
    end else begin
      wes = 1;
      if (size == 2) begin
        ref_mem[idx] = wdata;
      end else begin
        lat = 3;
        sh = 8 * off;
        mask = ((size == 0) ? 32'hFF : 32'hFFFF) << sh;
        ref_mem[idx] = (word & ~mask) | ((wdata << sh) & mask);
      end
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (req_ready !== 1'b1)   begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0)  begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
    checks++; if (resp_err !== 1'b0)    begin failures++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    checks++; if (mem_we !== 1'b0)      begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_wd !== 32'h0)     begin failures++; $display("FAIL reset_mem_wd got=%h exp=0", mem_wd); end
  endtask

  task automatic test_word_load();
    logic [31:0] rd, wd; logic er; int lat, wc, wy;
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, er, lat, wc, wy, wd);
    checks++; if (rd !== 32'h8) begin failures++; $display("FAIL lw_data got=%h exp=00000008", rd); end
    checks++; if (er !== 1'b0)  begin failures++; $display("FAIL lw_err got=%b exp=0", er); end
    checks++; if (lat !== 2)    begin failures++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    checks++; if (wc !== 0)     begin failures++; $display("FAIL lw_mem_we got=%0d pulses exp=0", wc); end
  endtask

  task automatic test_subword_loads();
    logic [31:0] rd, wd; logic er; int lat, wc, wy;
    poke(1, 32'h80FF_7F01);
    do_req(1'b0, 2'b00, 1'b0, 32'h6, 32'h0, rd, er, lat, wc, wy, wd);
    checks++; if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL lb_data got=%h exp=ffffffff", rd); end
    do_req(1'b0, 2'b00, 1'b1, 32'h6, 32'h0, rd, er, lat, wc, wy, wd);
    checks++; if (rd !== 32'h0000_00FF) begin failures++; $display("FAIL lbu_data got=%h exp=000000ff", rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, rd, er, lat, wc, wy, wd);
    checks++; if (rd !== 32'hFFFF_80FF) begin failures++; $display("FAIL lh_data got=%h exp=ffff80ff", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h4, 32'h0, rd, er, lat, wc, wy, wd);
    checks++; if (rd !== 32'h0000_7F01) begin failures++; $display("FAIL lhu_data got=%h exp=00007f01", rd); end
    checks++; if (lat !== 2)            begin failures++; $display("FAIL lhu_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_rmw_store();
    logic [31:0] rd, wd, mrd; logic er, mer; int lat, wc, wy, mlat, mwes;
    poke(1, 32'h1122_3344);
    do_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AB, rd, er, lat, wc, wy, wd);
    model(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AB, mrd, mer, mlat, mwes);
    checks++; if (wc !== 1)             begin failures++; $display("FAIL sb_we_pulses got=%0d exp=1", wc); end
    checks++; if (wy !== 2)             begin failures++; $display("FAIL sb_we_cycle got=%0d exp=2", wy); end
    checks++; if (wd !== 32'h1122_AB44) begin failures++; $display("FAIL sb_mem_wd got=%h exp=1122ab44", wd); end
    checks++; if (lat !== 3)            begin failures++; $display("FAIL sb_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL sb_resp got=%h/%b exp=0/0", rd, er); end
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd, er, lat, wc, wy, wd);
    checks++; if (rd !== 32'h1122_AB44) begin failures++; $display("FAIL sb_readback got=%h exp=1122ab44", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, wd; logic er; int lat, wc, wy;
    logic        t_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  t_size [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
    logic [31:0] t_addr [4] = '{32'h3, 32'h102, 32'h100, 32'h0};
    for (int i = 0; i < 4; i++) begin
      do_req(t_we[i], t_size[i], 1'b0, t_addr[i], 32'hCAFE_F00D, rd, er, lat, wc, wy, wd);
      checks++; if (er !== 1'b1) begin failures++; $display("FAIL err%0d_flag got=%b exp=1", i, er); end
      checks++; if (wc !== 0)    begin failures++; $display("FAIL err%0d_mem_we got=%0d exp=0", i, wc); end
      checks++; if (lat !== 2 || rd !== 32'h0) begin failures++; $display("FAIL err%0d_resp got lat=%0d rdata=%h exp lat=2 rdata=0", i, lat, rd); end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, mrd, addr, wdata; logic er, mer, we, uns; logic [1:0] size;
    int lat, wc, wy, mlat, mwes, r;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      size = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      we = 1'($urandom); uns = 1'($urandom); wdata = $urandom;
      r = $urandom_range(0, 15);
      addr = (r == 0) ? $urandom : (r == 1) ? $urandom_range(256, 1023) : $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0 && size != 2'b11) addr = addr & ~((32'h1 << size) - 1);
      do_req(we, size, uns, addr, wdata, rd, er, lat, wc, wy, wd);
      model(we, size, uns, addr, wdata, mrd, mer, mlat, mwes);
      checks++; if (rd !== mrd)   begin failures++; $display("FAIL rand%0d_rdata got=%h exp=%h", n, rd, mrd); end
      checks++; if (er !== mer)   begin failures++; $display("FAIL rand%0d_err got=%b exp=%b", n, er, mer); end
      checks++; if (lat !== mlat) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", n, lat, mlat); end
      checks++; if (wc !== mwes)  begin failures++; $display("FAIL rand%0d_we_pulses got=%0d exp=%0d", n, wc, mwes); end
      if (mwes == 1) begin
        checks++; if (wd !== ref_mem[addr / 4]) begin failures++; $display("FAIL rand%0d_mem_wd got=%h exp=%h", n, wd, ref_mem[addr / 4]); end
      end
    end
    for (int k = 0; k < 64; k++) begin
      checks++; if (mem[k] !== ref_mem[k]) begin failures++; $display("FAIL mem_word%0d got=%h exp=%h", k, mem[k], ref_mem[k]); end
    end
  endtask

  task automatic test_reset_abort();
    bit saw_we = 0;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h8; req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (mem_we) saw_we = 1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL abort_req_ready got=%b exp=1", req_ready); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (mem_we) saw_we = 1;
      @(negedge clk);
    end
    checks++; if (saw_we !== 1'b0)        begin failures++; $display("FAIL abort_mem_we got=%b exp=0", saw_we); end
    checks++; if (mem[2] !== ref_mem[2]) begin failures++; $display("FAIL abort_mem got=%h exp=%h", mem[2], ref_mem[2]); end
  endtask

`ifdef LSU_STATS_EN
  task automatic test_stats();
    logic [31:0] rd, wd; logic er; int lat, wc, wy;
    reset_dut();
    do_req(1'b0, 2'b10, 1'b0, 32'h0,  32'h0, rd, er, lat, wc, wy, wd);
    do_req(1'b0, 2'b10, 1'b0, 32'h4,  32'h0, rd, er, lat, wc, wy, wd);
    do_req(1'b0, 2'b00, 1'b1, 32'h9,  32'h0, rd, er, lat, wc, wy, wd);
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678, rd, er, lat, wc, wy, wd);
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h55, rd, er, lat, wc, wy, wd);
    do_req(1'b0, 2'b01, 1'b0, 32'h3,  32'h0, rd, er, lat, wc, wy, wd);
    @(negedge clk);
    checks++; if (load_count !== 16'd3)  begin failures++; $display("FAIL stats_load got=%0d exp=3", load_count); end
    checks++; if (store_count !== 16'd2) begin failures++; $display("FAIL stats_store got=%0d exp=2", store_count); end
    checks++; if (err_count !== 16'd1)   begin failures++; $display("FAIL stats_err got=%0d exp=1", err_count); end
    reset_dut();
    checks++; if (load_count !== 16'd0 || store_count !== 16'd0 || err_count !== 16'd0) begin
      failures++; $display("FAIL stats_reset got=%0d/%0d/%0d exp=0/0/0", load_count, store_count, err_count);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    poke_idx = 6'h0; poke_data = 32'h0;
    for (int k = 0; k < 64; k++) poke(k, (k <= 10) ? 32'(10 - k) : $urandom);
    test_reset();
    test_word_load();
    test_subword_loads();
    test_rmw_store();
    test_errors();
    test_random();
    test_reset_abort();
`ifdef LSU_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the datapath (ALU result, rt value) and the word-addressed data memory.
- Converts byte-addressed MIPS loads/stores into word-memory accesses: lb/lbu/lh/lhu/lw and sb/sh/sw.
- Sub-word stores use read-modify-write. Misaligned and out-of-range accesses are reported instead of executed.
- Multi-cycle with a valid/ready request side and a one-cycle response pulse; the core stalls while req_ready is low.

Parameters:
- MEM_AW, 6: word-address width of data memory (64 words).
- MEM_WORDS, 64: number of implemented words. Any word index >= MEM_WORDS is out of range.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle, request accepted when req_valid & req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word. 11 is illegal and reported as an error.
- req_unsigned  input  1  zero-extend loads (lbu/lhu). Ignored for stores and word loads.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data, valid with resp_valid. 0 for stores and errors.
- resp_err  output  1  with resp_valid: misaligned, out-of-range or illegal size.
- mem_addr  output  MEM_AW  word index, = addr_q[MEM_AW+1:2].
- mem_we  output  1  memory write enable, sampled by memory on clk.
- mem_wd  output  32  memory write data.
- mem_rd  input  32  combinational memory read data for mem_addr.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE. req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_wd=0.
  - Request registers clear. Reset mid-operation aborts immediately and any pending write is dropped.
- Byte order is little-endian: byte lane k = addr[1:0]==k occupies bits [8k+7:8k]. Half lane = addr[1].
- On accept, latch we, size, unsigned, addr and wdata into *_q registers and check legality:
  - half needs addr[0]==0; word needs addr[1:0]==0;
  - req_size==11 is illegal;
  - addr[31:2] >= MEM_WORDS is out of range.
- States:
  - IDLE: req_ready=1. On accept: go to ERR if illegal, else LOAD if !we, STORE_W if word store, RMW_RD if sub-word store.
  - LOAD: mem_addr driven. Select lane from mem_rd, sign- or zero-extend, register into resp_rdata. Next state RESP.
  - STORE_W: mem_we=1, mem_wd=wdata_q. Next state RESP.
  - RMW_RD: latch mem_rd into old_q. Next state RMW_WR.
  - RMW_WR: mem_we=1, mem_wd=old_q with the selected byte/half lane replaced by wdata_q[7:0]/[15:0]. Next state RESP.
  - ERR: no memory access, mem_we stays 0. Next state RESP with resp_err=1.
  - RESP: resp_valid=1 for exactly one cycle. Next state IDLE.
- req_ready is 1 only in IDLE. A new request can be accepted the cycle after RESP.
- Latency from the accept edge to the resp_valid cycle: load 2, word store 2, sub-word store 3, error 2.
- mem_we is never asserted outside STORE_W and RMW_WR, and is high for exactly one cycle per store.
- Request inputs are ignored when req_ready=0.
- resp_rdata and resp_err hold their values until the next RESP cycle.

Optional Feature:
- Macro: LSU_STATS_EN.
- When defined, add output ports load_count[15:0], store_count[15:0] and err_count[15:0].
  - Each increments on the RESP cycle of its kind (errors count only in err_count).
  - Each saturates at 16'hFFFF and clears on reset.
- When undefined, these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Bench memory preset mem[k]=10-k for k=0..10. lw addr=0x8 -> resp_valid 2 cycles after accept, resp_rdata=0x00000008, resp_err=0.
- Preload mem[1]=0x80FF7F01:
  - lb addr=0x6 -> 0xFFFFFFFF;
  - lbu addr=0x6 -> 0x000000FF;
  - lh addr=0x6 -> 0xFFFF80FF;
  - lhu addr=0x4 -> 0x00007F01.
- sb wdata=0xAB addr=0x5 with mem[1]=0x11223344 -> exactly one mem_we pulse in cycle 2, mem_wd=0x1122AB44, resp_valid in cycle 3. A following lw addr=0x4 returns 0x1122AB44.
- Errors, each with no mem_we and resp_valid with resp_err=1:
  - lh addr=0x3;
  - sw addr=0x102;
  - lw addr=0x100 (word 64 >= MEM_WORDS);
  - req_size=11.
- Assert reset in RMW_RD of an sh -> next cycle req_ready=1, mem_we never asserted, memory unchanged.
- With LSU_STATS_EN: 3 loads, 2 stores, 1 misaligned -> load_count=3, store_count=2, err_count=1. Then reset -> all three counters 0.
